// File: rtl/pet2001_prg_loader.sv
// -----------------------------------------------------------------------------
// pet2001_prg_loader
//
// Streams a Commodore PRG file into PET RAM through the hardware DMA port.
// A PRG file is a two-byte little-endian load address followed by the program
// body. Every body byte is written to consecutive RAM addresses. After a clean
// download, the BASIC end pointers (VARTAB, ARYTAB, STREND) in zero page are
// patched to point one past the last loaded byte. This lets BASIC see the
// program as if it had been LOADed.
//
// Parameters
//   PTR_BASE    zero-page address of VARTAB; ARYTAB/STREND sit at +2/+4
//   PATCH_PTRS  non-zero enables the six-cycle pointer patch phase
//
// Ports
//   clk        system clock, rising-edge active
//   reset_n    asynchronous active-low reset
//   dl_active  high while a file download is in progress
//   in_valid   in_data holds a file byte
//   in_data    file byte, in file order
//   in_ready   loader accepts a byte this cycle
//   dma_addr   RAM write address
//   dma_din    RAM write data
//   dma_we     single-cycle write strobe
//   busy       download/patch in progress
//   done       one-cycle pulse on successful completion
//   error      sticky error flag, cleared when the next download starts
// -----------------------------------------------------------------------------
module pet2001_prg_loader #(
  parameter logic [7:0] PTR_BASE   = 8'h2A,
  parameter int         PATCH_PTRS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_PTR,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_dl_prev;
  logic [15:0] r_load_addr;
  logic [16:0] r_cur_addr;
  logic [2:0]  r_ptr_idx;
  logic [15:0] r_dma_addr;
  logic [7:0]  r_dma_din;
  logic        r_dma_we;
  logic        r_done;
  logic        r_error;

  logic        w_rise;
  logic        w_fall;
  logic        w_accept;
  logic        w_in_ram;
  logic        w_data_err;
  logic        w_patch_en;
  logic [15:0] w_end_addr;
  logic [7:0]  w_ptr_lo;

  // The edge detector compares the live dl_active with its value one clock
  // earlier. A start or stop is therefore acted on at the first clock edge
  // that sees the new level.
  assign w_rise = dl_active & ~r_dl_prev;
  assign w_fall = ~dl_active & r_dl_prev;

  // The loader only takes bytes while it is parsing the header or the body.
  assign in_ready = (r_state == S_HDR_LO) || (r_state == S_HDR_HI) || (r_state == S_DATA);
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_accept = in_valid & in_ready;

  // The upper 32K is ROM/IO space, so only addresses below 0x8000 may be
  // written. The cur_addr register is 17 bits wide, so the address can
  // never wrap back into RAM.
  assign w_in_ram   = ~r_cur_addr[16] & ~r_cur_addr[15];
  assign w_data_err = w_accept & ~w_in_ram;
  assign w_patch_en = (PATCH_PTRS != 0);
  assign w_end_addr = r_cur_addr[15:0];
  assign w_ptr_lo   = PTR_BASE + {5'b00000, r_ptr_idx};

  assign dma_addr = r_dma_addr;
  assign dma_din  = r_dma_din;
  assign dma_we   = r_dma_we;
  assign done     = r_done;
  assign error    = r_error;

  // Main loader FSM. The write strobe and done are pulses that default low
  // every cycle. A dl_active rise outranks everything else, so a new
  // download always starts cleanly. A fall that coincides with an accepted
  // byte lets that byte be processed first, and the state moves on afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_dl_prev   <= 1'b0;
      r_load_addr <= 16'h0000;
      r_cur_addr  <= 17'h00000;
      r_ptr_idx   <= 3'd0;
      r_dma_addr  <= 16'h0000;
      r_dma_din   <= 8'h00;
      r_dma_we    <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_dl_prev <= dl_active;
      r_dma_we  <= 1'b0;
      r_done    <= 1'b0;

      if (w_rise) begin
        r_state    <= S_HDR_LO;
        r_error    <= 1'b0;
        r_cur_addr <= 17'h00000;
        r_ptr_idx  <= 3'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end

          S_HDR_LO: begin
            if (w_accept) begin
              r_load_addr[7:0] <= in_data;
            end
            if (w_fall) begin
              r_error <= 1'b1;
              r_state <= S_DONE;
            end else if (w_accept) begin
              r_state <= S_HDR_HI;
            end
          end

          S_HDR_HI: begin
            if (w_accept) begin
              r_load_addr[15:8] <= in_data;
              r_cur_addr        <= {1'b0, in_data, r_load_addr[7:0]};
              r_ptr_idx         <= 3'd0;
              // A header that completes on the stop edge is a zero-length file.
              if (w_fall) begin
                r_state <= (w_patch_en && !r_error) ? S_PTR : S_DONE;
              end else begin
                r_state <= S_DATA;
              end
            end else if (w_fall) begin
              r_error <= 1'b1;
              r_state <= S_DONE;
            end
          end

          S_DATA: begin
            if (w_accept) begin
              if (w_in_ram) begin
                r_dma_addr <= r_cur_addr[15:0];
                r_dma_din  <= in_data;
                r_dma_we   <= 1'b1;
              end else begin
                r_error <= 1'b1;
              end
              if (!(&r_cur_addr)) begin
                r_cur_addr <= r_cur_addr + 17'd1;
              end
            end
            if (w_fall) begin
              r_ptr_idx <= 3'd0;
              r_state   <= (w_patch_en && !(r_error || w_data_err)) ? S_PTR : S_DONE;
            end
          end

          // Even indices carry the end address low byte and odd indices the
          // high byte. The same value goes to all three pointers.
          S_PTR: begin
            r_dma_addr <= {8'h00, w_ptr_lo};
            r_dma_din  <= r_ptr_idx[0] ? w_end_addr[15:8] : w_end_addr[7:0];
            r_dma_we   <= 1'b1;
            if (r_ptr_idx == 3'd5) begin
              r_state <= S_DONE;
            end else begin
              r_ptr_idx <= r_ptr_idx + 3'd1;
            end
          end

          S_DONE: begin
            r_done  <= ~r_error;
            r_state <= S_IDLE;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pet2001_prg_loader.sv
// -----------------------------------------------------------------------------
// tb_pet2001_prg_loader
//
// Drives PRG file streams into two loaders. One loader patches the BASIC end
// pointers and the other has pointer patching disabled. The bench records
// every RAM write and done pulse, and compares them with a file-level model of
// what a PRG load must produce.
// -----------------------------------------------------------------------------
module tb_pet2001_prg_loader;

  logic        clk;
  logic        reset_n;
  logic        dl_active;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready,  in_ready_np;
  logic [15:0] dma_addr,  dma_addr_np;
  logic [7:0]  dma_din,   dma_din_np;
  logic        dma_we,    dma_we_np;
  logic        busy,      busy_np;
  logic        done,      done_np;
  logic        error,     error_np;

  logic [7:0]  fileQ[$];
  logic [23:0] obsQ[$];
  logic [23:0] obsNpQ[$];
  logic [23:0] expQ[$];
  logic [23:0] expNpQ[$];
  int          doneCnt;
  int          doneNpCnt;
  int          expDoneCnt;
  bit          expErr;

  int checks;
  int errors;

  pet2001_prg_loader #(.PTR_BASE(8'h2A), .PATCH_PTRS(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .dl_active(dl_active),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we),
    .busy(busy), .done(done), .error(error)
  );

  pet2001_prg_loader #(.PTR_BASE(8'h2A), .PATCH_PTRS(0)) u_dut_np (
    .clk(clk), .reset_n(reset_n), .dl_active(dl_active),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_np),
    .dma_addr(dma_addr_np), .dma_din(dma_din_np), .dma_we(dma_we_np),
    .busy(busy_np), .done(done_np), .error(error_np)
  );

  // 100 MHz style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record writes and done pulses at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (dma_we)    obsQ.push_back({dma_addr, dma_din});
    if (dma_we_np) obsNpQ.push_back({dma_addr_np, dma_din_np});
    if (done)      doneCnt++;
    if (done_np)   doneNpCnt++;
  end

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearRun();
    obsQ.delete();
    obsNpQ.delete();
    expQ.delete();
    expNpQ.delete();
    doneCnt    = 0;
    doneNpCnt  = 0;
    expDoneCnt = 0;
    expErr     = 1'b0;
  endtask

  // File-level reference model: the body lands at load_addr onward, but only
  // below 0x8000. Any byte that would land above that marks the file bad. A
  // clean, non-aborted file earns three end pointers and a done pulse.
  task automatic modelFile(input bit aborted);
    int         addr;
    bit         err;
    logic [7:0] pa;
    logic [7:0] pd;
    err  = 1'b0;
    addr = 0;
    if (fileQ.size() < 2) begin
      err = 1'b1;
    end else begin
      addr = {16'h0000, fileQ[1], fileQ[0]};
      for (int i = 2; i < fileQ.size(); i++) begin
        if (addr < 32768) begin
          expQ.push_back({addr[15:0], fileQ[i]});
          expNpQ.push_back({addr[15:0], fileQ[i]});
        end else begin
          err = 1'b1;
        end
        addr++;
      end
      if (!err && !aborted) begin
        for (int k = 0; k < 6; k++) begin
          pa = 8'h2A + k[7:0];
          pd = (k % 2 == 1) ? addr[15:8] : addr[7:0];
          expQ.push_back({8'h00, pa, pd});
        end
      end
    end
    if (!err && !aborted) expDoneCnt++;
    expErr = err;
  endtask

  // Present every byte of fileQ. gapMode 0 means back-to-back, 1 means
  // alternating idle cycles, and 2 means random gaps. With coincide set,
  // dl_active drops together with the last byte.
  task automatic applyStimulus(input int gapMode, input bit coincide);
    int t;
    for (int i = 0; i < fileQ.size(); i++) begin
      in_valid = 1'b1;
      in_data  = fileQ[i];
      if (coincide && (i == fileQ.size() - 1)) dl_active = 1'b0;
      t = 0;
      while (!in_ready && t < 20) begin
        step();
        t++;
      end
      if (!in_ready) checkOutput("readyTimeout", 32'd0, 32'd1);
      step();
      in_valid = 1'b0;
      if (gapMode == 1) step();
      else if (gapMode == 2) repeat ($urandom_range(0, 2)) step();
    end
    in_valid = 1'b0;
  endtask

  task automatic compareRun(input string name);
    checkOutput($sformatf("%s nWrites", name), obsQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
      checkOutput($sformatf("%s wr%0d", name, i), {8'h00, obsQ[i]}, {8'h00, expQ[i]});
    checkOutput($sformatf("%s np nWrites", name), obsNpQ.size(), expNpQ.size());
    for (int i = 0; i < expNpQ.size() && i < obsNpQ.size(); i++)
      checkOutput($sformatf("%s np wr%0d", name, i), {8'h00, obsNpQ[i]}, {8'h00, expNpQ[i]});
    checkOutput($sformatf("%s done", name), doneCnt, expDoneCnt);
    checkOutput($sformatf("%s np done", name), doneNpCnt, expDoneCnt);
    checkOutput($sformatf("%s error", name), {31'd0, error}, {31'd0, expErr});
    checkOutput($sformatf("%s np error", name), {31'd0, error_np}, {31'd0, expErr});
    checkOutput($sformatf("%s busy", name), {31'd0, busy}, 32'd0);
  endtask

  task automatic runFile(input string name, input int gapMode, input bit coincide);
    clearRun();
    modelFile(1'b0);
    dl_active = 1'b1;
    step();
    applyStimulus(gapMode, coincide);
    dl_active = 1'b0;
    repeat (14) step();
    compareRun(name);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput($sformatf("%s in_ready", name), {31'd0, in_ready}, 32'd0);
    checkOutput($sformatf("%s dma_addr", name), {16'd0, dma_addr}, 32'd0);
    checkOutput($sformatf("%s dma_din", name), {24'd0, dma_din}, 32'd0);
    checkOutput($sformatf("%s dma_we", name), {31'd0, dma_we}, 32'd0);
    checkOutput($sformatf("%s busy", name), {31'd0, busy}, 32'd0);
    checkOutput($sformatf("%s done", name), {31'd0, done}, 32'd0);
    checkOutput($sformatf("%s error", name), {31'd0, error}, 32'd0);
  endtask

  initial begin
    int len;
    int load;
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    dl_active = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    clearRun();
    repeat (3) step();
    checkAllZero("reset");
    reset_n = 1'b1;
    repeat (3) step();
    checkOutput("postReset writes", obsQ.size(), 32'd0);

    fileQ = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
    runFile("basic", 0, 1'b0);

    fileQ = '{8'hFE, 8'h7F, 8'h11, 8'h22, 8'h33};
    runFile("romEdge", 0, 1'b0);

    fileQ = '{8'h01};
    runFile("shortHdr", 0, 1'b0);

    fileQ = '{8'h00, 8'h10};
    runFile("hdrOnly", 0, 1'b0);

    fileQ = '{8'h01, 8'h04};
    for (int i = 0; i < 200; i++) fileQ.push_back(8'($urandom));
    runFile("toggle200", 1, 1'b0);

    // Reset in the middle of a file, then a fresh download.
    clearRun();
    fileQ = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
    modelFile(1'b1);
    dl_active = 1'b1;
    step();
    applyStimulus(0, 1'b0);
    step();
    step();
    reset_n = 1'b0;
    #1;
    checkAllZero("midReset");
    dl_active = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    repeat (3) step();
    compareRun("midReset");
    runFile("afterReset", 0, 1'b0);

    // A one-cycle drop of dl_active restarts without patching pointers.
    clearRun();
    fileQ = '{8'h01, 8'h04, 8'hAA, 8'hBB};
    modelFile(1'b1);
    dl_active = 1'b1;
    step();
    applyStimulus(0, 1'b0);
    dl_active = 1'b0;
    step();
    dl_active = 1'b1;
    step();
    fileQ = '{8'h00, 8'h20, 8'h5A, 8'hA5};
    modelFile(1'b0);
    applyStimulus(0, 1'b0);
    dl_active = 1'b0;
    repeat (14) step();
    compareRun("restart");

    for (int n = 0; n < 25; n++) begin
      fileQ.delete();
      if ($urandom_range(0, 9) == 0) begin
        len = $urandom_range(0, 1);
        for (int i = 0; i < len; i++) fileQ.push_back(8'($urandom));
      end else begin
        load = ($urandom_range(0, 2) == 0) ? int'($urandom_range(16'h7FD8, 16'h7FFF))
                                           : int'($urandom_range(0, 16'hFFFF));
        fileQ.push_back(load[7:0]);
        fileQ.push_back(load[15:8]);
        len = $urandom_range(0, 40);
        for (int i = 0; i < len; i++) fileQ.push_back(8'($urandom));
      end
      runFile($sformatf("rand%0d", n), 2, (fileQ.size() >= 3) && ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
